pipe_share_ctrl: RTL and testbench
==================================

Name: pipe_share_ctrl

Overview:
Shares one 3-stage arithmetic pipeline, F = ((A+B) + (C-D)) * D, between NREQ requesters.
- Arbitrates round-robin, issues at most one operand set per clock, and carries a requester-ID tag and valid bit alongside the data through every stage.
- Returns each result with its ID.
- Sits between the client blocks and the arithmetic datapath; the datapath stages are implemented inside this block.

Parameters:
N, 10, operand/result width in bits
NREQ, 4, number of requesters (2..8)
IDW, clog2(NREQ), width of requester ID

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
issue_en  in  1  1 = grants allowed; 0 = no new grants, in-flight work drains
req  in  NREQ  per-requester request, held with operands until granted
op_a  in  NREQ*N  packed A operands, slice i = requester i
op_b  in  NREQ*N  packed B operands
op_c  in  NREQ*N  packed C operands
op_d  in  NREQ*N  packed D operands
gnt  out  NREQ  one-hot grant, combinational, same cycle as accept
res_valid  out  1  one-cycle pulse, result present
res_id  out  IDW  requester owning res_data
res_data  out  N  result F
busy  out  1  any stage valid

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0, all data/tag regs 0, RR pointer = 0. Resulting outputs: res_valid=0, res_id=0, res_data=0, busy=0, gnt=0.
- Arbitration:
  - The candidate set is req & {NREQ{issue_en}}.
  - The winner is the first set bit searching upward from ptr, wrapping.
  - gnt is one-hot for the winner and all-zero if there is none.
- Accept: on the rising edge where gnt[i]=1, stage1 captures slice i of op_a..op_d and tag i, and sets v1=1. The requester may drop req or present a new operation the following cycle.
- Pointer update: on accept, ptr <= winner+1 mod NREQ. With no accept, ptr holds.
- Stage 1: x1 = A+B, x2 = C-D, d1 = D, v1, id1.
- Stage 2: x3 = x1+x2, d2 = d1, v2 <= v1, id2 <= id1.
- Stage 3: F = x3*d2, low N bits; res_valid <= v2, res_id <= id2.
- Latency: exactly 3 clocks from the accept edge to res_valid high. Throughput is 1 per clock with no bubbles.
- Widths: all sums and differences are modulo 2^N (unsigned wrap). The product keeps only the low N bits.
- No backpressure on the result side. The consumer must accept every res_valid pulse.
- Data/tag registers load only when the upstream valid is 1, so res_data and res_id hold their last value while res_valid=0.
- busy = v1|v2|v3, where v3 is the res_valid register.
- issue_en low mid-stream: gnt goes to 0 that cycle. Already-accepted operations still complete; the pipeline drains in 3 cycles.
- req dropped before being granted: no operation, no error.
- Single requester: granted every cycle it requests.
- Reset mid-operation: in-flight operations are discarded and produce no res_valid after release.

Optional Feature:
PIPE_SHARE_CNT_EN:
- Defined: adds output port done_cnt[15:0]. It increments on each res_valid pulse, wraps 65535->0, and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pipe_share_pkg holds:
  - default N and NREQ;
  - localparam PIPE_LAT = 3;
  - an ID-width function (clog2).
- One sub-module, rr_arbiter. Inputs: clk, rst, req, accept-enable. Outputs: one-hot gnt and encoded winner. It owns the pointer.
- Datapath stages stay in pipe_share_ctrl.

Test Plan:
1. Reset then req[0]=1, A=5, B=3, C=10, D=4 -> gnt[0] same cycle; 3 clocks later res_valid=1, res_id=0, res_data=56 for one cycle.
2. Wrap: req[2] with A=1000, B=100, C=0, D=2 (N=10) -> res_data=148, res_id=2.
3. req=4'b1111 held 5 cycles, distinct operands -> grants 0,1,2,3,0 on consecutive cycles; results 3 cycles later in the same ID order with correct values.
4. req=4'b1111 with issue_en dropped after 2 grants -> gnt=0 while low, busy stays 1 for 3 more cycles then 0; exactly 2 res_valid pulses. On re-enable the next grant goes to ID 2.
5. Three operations in flight, rst pulsed -> all outputs 0 asynchronously; no res_valid afterwards; next grant goes to ID 0.
6. With PIPE_SHARE_CNT_EN defined, 70000 back-to-back results -> done_cnt = 4464 (wrapped).

Source files
------------

// File: rtl/pipe_share_pkg.sv
// pipe_share_pkg: shared defaults and helpers for pipe_share_ctrl.
//   DEF_N    - default operand/result width
//   DEF_NREQ - default requester count
//   PIPE_LAT - clocks from accept edge to res_valid
//   id_width - ceil(log2(n)), at least 1
package pipe_share_pkg;

  localparam int DEF_N    = 10;
  localparam int DEF_NREQ = 4;
  localparam int PIPE_LAT = 3;

  function automatic int id_width(input int n);
    int w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter owning the search pointer.
// Ports:
//   clk, rst - clock, async active-high reset (ptr -> 0)
//   req      - per-requester request
//   en       - grants allowed when 1
//   gnt      - combinational one-hot grant (all-zero when no winner)
//   winner   - encoded index of the granted requester
module rr_arbiter
  import pipe_share_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  winner
);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] cand;
  logic            found;
  int unsigned     idx;

  // Reset also masks the candidates so gnt reads 0 while rst is held.
  assign cand = req & {NREQ{en & ~rst}};

  // First candidate at or above ptr, wrapping modulo NREQ.
  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (k + ptr) % NREQ;
      if (!found && cand[idx]) begin
        found    = 1'b1;
        winner   = IDW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      if (winner == IDW'(NREQ - 1)) ptr <= '0;
      else                          ptr <= winner + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_share_ctrl.sv
// pipe_share_ctrl: shares a 3-stage pipeline F = ((A+B)+(C-D))*D, all
// arithmetic modulo 2^N, among NREQ requesters with round-robin issue.
// Ports:
//   clk, rst        - clock, async active-high reset
//   issue_en        - 1 allows new grants; 0 lets in-flight work drain
//   req             - per-requester request, held with operands until granted
//   op_a..op_d      - packed operands, slice i belongs to requester i
//   gnt             - combinational one-hot grant
//   res_valid       - one-cycle result pulse
//   res_id/res_data - owner and value of the result (held between pulses)
//   busy            - any pipeline stage valid
//   done_cnt        - result counter, present only with PIPE_SHARE_CNT_EN
module pipe_share_ctrl
  import pipe_share_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] op_a,
  input  logic [NREQ*N-1:0] op_b,
  input  logic [NREQ*N-1:0] op_c,
  input  logic [NREQ*N-1:0] op_d,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  output logic [IDW-1:0]    res_id,
  output logic [N-1:0]      res_data,
  output logic              busy
`ifdef PIPE_SHARE_CNT_EN
  ,
  output logic [15:0]       done_cnt
`endif
);

  logic [IDW-1:0] winner;
  logic           accept;
  logic [N-1:0]   sa, sb, sc, sd;

  logic           v1, v2, v3;
  logic [N-1:0]   x1, x2, d1, x3, d2;
  logic [IDW-1:0] id1, id2;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .en     (issue_en),
    .gnt    (gnt),
    .winner (winner)
  );

  assign accept    = |gnt;
  assign sa        = op_a[winner*N +: N];
  assign sb        = op_b[winner*N +: N];
  assign sc        = op_c[winner*N +: N];
  assign sd        = op_d[winner*N +: N];
  assign res_valid = v3;
  assign busy      = v1 | v2 | v3;

  // Data/tag registers only load behind a valid, so outputs hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      x1 <= '0; x2 <= '0; d1 <= '0; id1 <= '0;
      x3 <= '0; d2 <= '0; id2 <= '0;
      res_data <= '0; res_id <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      if (accept) begin
        x1  <= sa + sb;
        x2  <= sc - sd;
        d1  <= sd;
        id1 <= winner;
      end
      if (v1) begin
        x3  <= x1 + x2;
        d2  <= d1;
        id2 <= id1;
      end
      if (v2) begin
        res_data <= N'(x3 * d2);
        res_id   <= id2;
      end
    end
  end

`ifdef PIPE_SHARE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     done_cnt <= '0;
    else if (v3) done_cnt <= done_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Testbench for pipe_share_ctrl (N=10, NREQ=4).
module tb_pipe_share_ctrl;
  import pipe_share_pkg::*;

  localparam int N    = 10;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              issue_en = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] op_a, op_b, op_c, op_d;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [N-1:0]      res_data;
  logic              busy;
`ifdef PIPE_SHARE_CNT_EN
  logic [15:0]       done_cnt;
`endif

  logic [N-1:0] a [NREQ];
  logic [N-1:0] b [NREQ];
  logic [N-1:0] c [NREQ];
  logic [N-1:0] d [NREQ];

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   pulses   = 0;
  int   p0;

  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign op_a[i*N +: N] = a[i];
    assign op_b[i*N +: N] = b[i];
    assign op_c[i*N +: N] = c[i];
    assign op_d[i*N +: N] = d[i];
  end

  pipe_share_ctrl #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .issue_en  (issue_en),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_c      (op_c),
    .op_d      (op_d),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
`ifdef PIPE_SHARE_CNT_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] fmodel(input logic [N-1:0] fa, fb, fc, fd);
    logic [N-1:0] s1, s2, s3;
    s1 = fa + fb;
    s2 = fc - fd;
    s3 = s1 + s2;
    return s3 * fd;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one cycle of stimulus right after a rising edge, checks gnt at
  // the falling edge, and records the expected result if a grant is due.
  task automatic step(input logic [NREQ-1:0] r, input logic en, input int exp_id);
    logic [NREQ-1:0] eg;
    req      = r;
    issue_en = en;
    @(negedge clk);
    eg = '0;
    if (exp_id >= 0) eg[exp_id] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    if (exp_id >= 0)
      sbq.push_back('{id: IDW'(exp_id),
                      data: fmodel(a[exp_id], b[exp_id], c[exp_id], d[exp_id])});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      exp_t e;
      pulses++;
      n_checks++;
      assert (sbq.size() != 0)
      else begin
        n_fails++;
        $error("FAIL res_extra: observed res_valid=1 expected no result (id %0d data %0d)",
               res_id, res_data);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_data", 32'(res_data), 32'(e.data));
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      a[i] = N'(11 * i + 2); b[i] = N'(7 * i + 1);
      c[i] = N'(100 + 3 * i); d[i] = N'(i + 3);
    end
    req = '1;
    issue_en = 1'b1;
    #2;
    // Reset state, with requests pending to confirm gnt is masked.
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req = '0;
    do_reset();

    // 1: basic op and exact latency.
    a[0] = 5; b[0] = 3; c[0] = 10; d[0] = 4;
    step(4'b0001, 1'b1, 0);
    chk("t1_lat1", 32'(res_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    step(4'b0000, 1'b1, -1);
    chk("t1_lat2", 32'(res_valid), 32'd0);
    step(4'b0000, 1'b1, -1);
    chk("t1_lat3", 32'(res_valid), 32'd1);
    chk("t1_id", 32'(res_id), 32'd0);
    chk("t1_data", 32'(res_data), 32'd56);
    step(4'b0000, 1'b1, -1);
    chk("t1_pulse", 32'(res_valid), 32'd0);
    chk("t1_hold", 32'(res_data), 32'd56);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: modular wrap, ptr=1 so requester 2 wins.
    a[2] = 1000; b[2] = 100; c[2] = 0; d[2] = 2;
    step(4'b0100, 1'b1, 2);
    repeat (2) step(4'b0000, 1'b1, -1);
    chk("t2_data", 32'(res_data), 32'd148);
    chk("t2_id", 32'(res_id), 32'd2);
    step(4'b0000, 1'b1, -1);

    // Single requester granted every cycle; new operands each time.
    for (int k = 0; k < 3; k++) begin
      step(4'b0010, 1'b1, 1);
      a[1] = a[1] + N'(9); d[1] = d[1] + N'(1);
    end
    // Request dropped before being granted.
    step(4'b0011, 1'b0, -1);
    step(4'b0000, 1'b1, -1);
    repeat (3) step(4'b0000, 1'b1, -1);

    // 3: all requesting from ptr=0, round-robin 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, k % NREQ);
      a[k % NREQ] = a[k % NREQ] + N'(37);
      c[k % NREQ] = c[k % NREQ] - N'(5);
    end
    repeat (4) step(4'b0000, 1'b1, -1);

    // 4: issue_en dropped after two grants.
    do_reset();
    p0 = pulses;
    step(4'b1111, 1'b1, 0);
    step(4'b1111, 1'b1, 1);
    chk("t4_busy0", 32'(busy), 32'd1);
    step(4'b1111, 1'b0, -1);
    chk("t4_busy1", 32'(busy), 32'd1);
    step(4'b1111, 1'b0, -1);
    chk("t4_busy2", 32'(busy), 32'd1);
    step(4'b1111, 1'b0, -1);
    chk("t4_busy3", 32'(busy), 32'd0);
    chk("t4_pulses", 32'(pulses - p0), 32'd2);
    step(4'b1111, 1'b1, 2);
    repeat (3) step(4'b0000, 1'b1, -1);

    // 5: async reset with three operations in flight (ptr=3 going in).
    step(4'b1111, 1'b1, 3);
    step(4'b1111, 1'b1, 0);
    step(4'b1111, 1'b1, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_valid", 32'(res_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_id", 32'(res_id), 32'd0);
    chk("t5_data", 32'(res_data), 32'd0);
    chk("t5_gnt", 32'(gnt), 32'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    p0 = pulses;
    repeat (4) step(4'b0000, 1'b1, -1);
    chk("t5_nores", 32'(pulses - p0), 32'd0);
    step(4'b1111, 1'b1, 0);
    repeat (3) step(4'b0000, 1'b1, -1);

`ifdef PIPE_SHARE_CNT_EN
    // 6: result counter wraps.
    do_reset();
    chk("t6_cnt0", 32'(done_cnt), 32'd0);
    for (int k = 0; k < 70000; k++) step(4'b0001, 1'b1, 0);
    repeat (4) step(4'b0000, 1'b1, -1);
    chk("t6_cnt", 32'(done_cnt), 32'd4464);
`endif

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
